// File: rtl/gray2bcd_pkg.sv
// ============================================================================
// Module      : gray2bcd_pkg
// Description : Shared types and constants for the serial Gray-to-BCD decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int ERRCNT_W    = 16;
    localparam int MAX_VAL_BCD = 9;

endpackage

`default_nettype wire

// File: rtl/gray_to_bcd_serial_if.sv
// ============================================================================
// Module      : gray_to_bcd_serial_if
// Description : Valid/ready input and output channels of the Gray decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gray_to_bcd_serial_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_gray;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_bin;
    logic             out_err;

    modport slave (
        input  in_valid, in_gray, out_ready,
        output in_ready, out_valid, out_bin, out_err
    );

    modport master (
        output in_valid, in_gray, out_ready,
        input  in_ready, out_valid, out_bin, out_err
    );
endinterface

`default_nettype wire

// File: rtl/gray_dec_shift.sv
// ============================================================================
// Module      : gray_dec_shift
// Description : Bit-serial Gray-to-binary datapath, MSB first, one bit/step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_dec_shift #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load_i,
    input  wire logic             step_i,
    input  wire logic [WIDTH-1:0] gray_i,
    output logic      [WIDTH-1:0] bin_d_o,
    output logic                  last_bit_o
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] g_q;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] w_prev;
    logic [IDX_W-1:0] idx_q;

    // Shifting right puts bin[idx+1] at position idx and a zero above the MSB.
    always_comb begin
        w_prev         = bin_q >> 1;
        bin_d_o        = bin_q;
        bin_d_o[idx_q] = g_q[idx_q] ^ w_prev[idx_q];
    end

    assign last_bit_o = (idx_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_q   <= '0;
            bin_q <= '0;
            idx_q <= '0;
        end else if (load_i) begin
            g_q   <= gray_i;
            bin_q <= '0;
            idx_q <= IDX_W'(WIDTH - 1);
        end else if (step_i) begin
            bin_q <= bin_d_o;
            if (idx_q != '0) begin
                idx_q <= idx_q - IDX_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/gray_to_bcd_serial.sv
// ============================================================================
// Module      : gray_to_bcd_serial
// Description : Serial Gray decoder with valid/ready handshakes and BCD range
//               flag. Define GRAY2BCD_ERRCNT_EN to add the err_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_to_bcd_serial
    import gray2bcd_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = MAX_VAL_BCD
) (
    input  wire logic              clk,
    input  wire logic              rst,
    gray_to_bcd_serial_if.slave    bus
`ifdef GRAY2BCD_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0]    err_cnt
`endif
);
    state_t           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_bin_q;
    logic             out_err_q;
    logic             w_accept;
    logic             w_step;
    logic             w_last_bit;
    logic [WIDTH-1:0] w_bin_d;

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_step        = (state_q == SHIFT);
    assign bus.out_valid = out_valid_q;
    assign bus.out_bin   = out_bin_q;
    assign bus.out_err   = out_err_q;

    gray_dec_shift #(
        .WIDTH (WIDTH)
    ) u_dec (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_accept),
        .step_i     (w_step),
        .gray_i     (bus.in_gray),
        .bin_d_o    (w_bin_d),
        .last_bit_o (w_last_bit)
    );

`ifdef GRAY2BCD_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_err_q   <= 1'b0;
`ifdef GRAY2BCD_ERRCNT_EN
            err_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Capture the word including the final LSB being resolved now.
                    if (w_last_bit) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_bin_q   <= w_bin_d;
                        out_err_q   <= (int'(w_bin_d) > MAX_VAL);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
`ifdef GRAY2BCD_ERRCNT_EN
                        if (out_err_q && (err_cnt_q != '1)) begin
                            err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
                        end
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gray_to_bcd_serial.sv
// ============================================================================
// Module      : tb_gray_to_bcd_serial
// Description : Self-checking bench for gray_to_bcd_serial (queue scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_to_bcd_serial;

    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gray_to_bcd_serial_if #(.WIDTH(WIDTH)) bus ();

`ifdef GRAY2BCD_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    gray_to_bcd_serial #(
        .WIDTH   (WIDTH),
        .MAX_VAL (9)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave)
`ifdef GRAY2BCD_ERRCNT_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    typedef struct packed {
        logic [WIDTH-1:0] bin;
        logic             err;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] gray;
        logic [WIDTH-1:0] bin;
        logic             err;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[16];

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int acc_cyc     = 0;
    int prev_acc    = -1;
    bit spacing_chk = 1'b0;
    bit ov_prev     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output side of the scoreboard: compare on every completed output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && !ov_prev)
                check("latency", 32'(cyc - acc_cyc), 32'(WIDTH + 1));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_output: got out_bin %0h with nothing expected", bus.out_bin);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_bin", 32'(bus.out_bin), 32'(mon_e.bin));
                    check("out_err", 32'(bus.out_err), 32'(mon_e.err));
                end
            end
            ov_prev <= bus.out_valid;
        end else begin
            ov_prev <= 1'b0;
        end
    end

    task automatic send(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] eb,
                        input logic ee, input bit hold);
        bit got;
        got = 1'b0;
        bus.in_gray  = g;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (bus.in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 for gray %0h", g);
        end else begin
            if (spacing_chk && prev_acc >= 0)
                check("accept_spacing", 32'(cyc - prev_acc), 32'(WIDTH + 2));
            prev_acc = cyc;
            acc_cyc  = cyc;
            sb.push_back('{bin: eb, err: ee});
        end
        #1;
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit saw_ready);
        bit got;
        got       = 1'b0;
        saw_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                got = 1'b1;
                break;
            end
            if (bus.in_ready) saw_ready = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: got out_valid 0 expected 1");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit busy_ready;
        bit stray;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_gray  = '0;
        bus.out_ready = 1'b0;

        // Sweep vectors built from the binary-to-Gray direction.
        for (int i = 0; i < 16; i++) begin
            vt[i].bin  = WIDTH'(i);
            vt[i].gray = WIDTH'(i ^ (i >> 1));
            vt[i].err  = (i > 9);
        end

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_bin",   32'(bus.out_bin),   32'd0);
        check("rst_out_err",   32'(bus.out_err),   32'd0);
`ifdef GRAY2BCD_ERRCNT_EN
        check("rst_err_cnt",   32'(err_cnt),       32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // Basic decode.
        bus.out_ready = 1'b1;
        send(4'b0110, 4'b0100, 1'b0, 1'b0);
        wait_valid(busy_ready);
        check("busy_in_ready", 32'(busy_ready), 32'd0);
        drain();

        // Range boundary.
        send(4'b1101, 4'b1001, 1'b0, 1'b0);
        drain();
        send(4'b1111, 4'b1010, 1'b1, 1'b0);
        drain();

        // Back-to-back sweep with in_valid held high.
        spacing_chk = 1'b1;
        prev_acc    = -1;
        for (int i = 0; i < 16; i++)
            send(vt[i].gray, vt[i].bin, vt[i].err, 1'b1);
        bus.in_valid = 1'b0;
        spacing_chk  = 1'b0;
        drain();

        // Backpressure.
        bus.out_ready = 1'b0;
        send(4'b0011, 4'b0010, 1'b0, 1'b0);
        wait_valid(busy_ready);
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_out_bin",   32'(bus.out_bin),   32'h2);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_valid_drop", 32'(bus.out_valid), 32'd0);
        check("bp_in_ready",   32'(bus.in_ready),  32'd1);
        check("bp_sb_empty",   32'(sb.size()),     32'd0);

        // Asynchronous reset during the second SHIFT cycle.
        send(4'b1010, 4'b1100, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        stray = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) stray = 1'b1;
        end
        check("post_rst_no_output", 32'(stray), 32'd0);
        send(4'b0001, 4'b0001, 1'b0, 1'b0);
        drain();

`ifdef GRAY2BCD_ERRCNT_EN
        check("errcnt_after_rst", 32'(err_cnt), 32'd0);
        send(4'b1111, 4'b1010, 1'b1, 1'b0);
        send(4'b1110, 4'b1011, 1'b1, 1'b0);
        send(4'b0000, 4'b0000, 1'b0, 1'b0);
        drain();
        check("errcnt_two", 32'(err_cnt), 32'd2);
        force dut.err_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.err_cnt_q;
        send(4'b1111, 4'b1010, 1'b1, 1'b0);
        drain();
        check("errcnt_saturate", 32'(err_cnt), 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gray_to_bcd_serial.md
Name: gray_to_bcd_serial

Overview:
- Decoding counterpart to the team's BCD-to-Gray encoders: accepts a Gray-coded word and recovers the binary/BCD value.
- Decodes bit-serially, MSB first, one bit per clock.
- Uses valid/ready handshakes on input and output.
- Flags results outside the legal BCD digit range; sits between a Gray-coded source (encoder output, position sensor) and BCD consumers.

Parameters:
- WIDTH, 4, bits per Gray/binary word (legal values 2..16).
- MAX_VAL, 9, largest legal decoded value; anything above it sets out_err.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_gray holds a word to decode.
- in_ready  output  1  block can accept a word.
- in_gray  input  WIDTH  Gray-coded input word.
- out_valid  output  1  out_bin/out_err hold a decoded result.
- out_ready  input  1  downstream accepts the result.
- out_bin  output  WIDTH  decoded binary value.
- out_err  output  1  high when out_bin > MAX_VAL.
- err_cnt  output  16  count of out-of-range results; present only with GRAY2BCD_ERRCNT_EN.

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - state=IDLE, internal shift/accumulator registers = 0, bit counter = 0.
  - out_valid=0, out_bin=0, out_err=0, err_cnt=0, in_ready=0.
- Reset mid-operation:
  - Aborts immediately; no partial result is emitted.
  - In-flight word is discarded and not counted.
- in_ready = (state==IDLE) && !rst, combinational from state.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with in_valid && in_ready, latch in_gray into g_reg.
  - Clear bin_reg; set idx=WIDTH-1; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT (one bit per cycle):
  - bin_reg[idx] <= g_reg[idx] ^ prev, where prev = 0 when idx==WIDTH-1, else bin_reg[idx+1].
  - If idx==0, go to DONE; else idx <= idx-1.
- DONE:
  - out_valid=1; out_bin=bin_reg (registered); out_err=(bin_reg > MAX_VAL), unsigned compare, registered on entry to DONE.
  - Outputs stay stable while out_ready=0 (backpressure, no time limit).
  - On an edge with out_ready=1, go to IDLE; out_valid drops the following cycle.
- Latency: accept edge E0 → WIDTH SHIFT edges → out_valid high after edge E0+WIDTH.
- Throughput: at most one word per WIDTH+2 cycles.
- in_valid while in SHIFT/DONE is ignored (in_ready=0). A source may hold in_valid; its word is taken on the first edge back in IDLE.
- out_ready while out_valid=0 has no effect.
- out_bin and out_err keep their last values in IDLE/SHIFT. Consumers must qualify them with out_valid.
- Decoding is pure XOR; all WIDTH-bit Gray inputs are legal. Only the value range is checked.

Optional Feature:
- GRAY2BCD_ERRCNT_EN defined:
  - Adds the err_cnt port.
  - Increments by 1 on each DONE→IDLE transition with out_err=1.
  - Saturates at 16'hFFFF; cleared only by rst.
- Not defined: err_cnt port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package gray2bcd_pkg:
  - state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - ERRCNT_W=16 constant.
  - Default MAX_VAL_BCD=9 constant.
- One sub-module, gray_dec_shift:
  - Holds g_reg, bin_reg, idx and the per-bit XOR step.
  - Controlled by load/step signals from the top-level FSM; reports last_bit.
- The top level holds the FSM, handshakes, range compare and the optional counter.

Test Plan:
- Basic decode: in_gray=4'b0110, out_ready=1 → out_valid exactly 4 cycles after accept; out_bin=4'b0100, out_err=0; in_ready=0 throughout.
- Boundary value: in_gray=4'b1101 → out_bin=4'b1001 (9), out_err=0. Then in_gray=4'b1111 → out_bin=4'b1010 (10), out_err=1.
- Exhaustive sweep: all 16 Gray codes back-to-back with in_valid held high → each out_bin equals the reference XOR-prefix decode. out_err=1 exactly for values 10..15; each word is accepted WIDTH+2 cycles apart.
- Backpressure: in_gray=4'b0011, out_ready=0 for 5 cycles after out_valid → out_bin=4'b0010 and out_valid stay stable. Raise out_ready → out_valid drops next cycle, then in_ready=1.
- Reset mid-operation: assert rst asynchronously (between edges) during the 2nd SHIFT cycle → out_valid=0, in_ready=0 immediately; after release, in_ready=1, no stray output, and the next word 4'b0001 decodes to 4'b0001.
- With GRAY2BCD_ERRCNT_EN: decode 4'b1111, 4'b1110, 4'b0000 → err_cnt=2. Preload to 16'hFFFF (force), decode 4'b1111 → err_cnt stays 16'hFFFF.
